// File: rtl/tpmem_pkg.sv
// Shared types and constants for the 16x16 transpose-memory ping-pong scheduler.
package tpmem_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } bank_state_e;

  localparam int ROWS       = 16;
  localparam int BW_DEFAULT = 11;

endpackage

// File: rtl/tpmem_bank_fsm.sv
// Per-bank fill/drain tracker: counts rows written into the bank and output
// cycles drained from it, flagging the 16th row and the final drain cycle.
module tpmem_bank_fsm
  import tpmem_pkg::*;
#(
  parameter int DRAIN_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr,
  input  logic        en,
  output bank_state_e state,
  output logic [3:0]  col_idx,
  output logic        row_last,
  output logic        done
);

  bank_state_e state_r, state_nxt_s;
  logic [3:0]  row_cnt_r, row_cnt_nxt_s;
  logic [7:0]  drain_cnt_r, drain_cnt_nxt_s;
  logic        drain_last_s;

  // Next-state logic; each counter only moves in its own phase.
  always_comb begin
    state_nxt_s     = state_r;
    row_cnt_nxt_s   = row_cnt_r;
    drain_cnt_nxt_s = drain_cnt_r;
    row_last        = 1'b0;
    done            = 1'b0;
    drain_last_s    = (drain_cnt_r == 8'(DRAIN_CYC - 1));
    case (state_r)
      EMPTY: begin
        if (wr) begin
          state_nxt_s   = FILL;
          row_cnt_nxt_s = row_cnt_r + 4'd1;
        end else begin
          state_nxt_s = EMPTY;
        end
      end
      FILL: begin
        if (wr) begin
          row_cnt_nxt_s = row_cnt_r + 4'd1;
          row_last      = (row_cnt_r == 4'(ROWS - 1));
          state_nxt_s   = row_last ? DRAIN : FILL;
        end else begin
          state_nxt_s = FILL;
        end
      end
      DRAIN: begin
        if (en) begin
          done            = drain_last_s;
          state_nxt_s     = drain_last_s ? EMPTY : DRAIN;
          drain_cnt_nxt_s = drain_last_s ? 8'd0 : drain_cnt_r + 8'd1;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: state_nxt_s = EMPTY;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= EMPTY;
      row_cnt_r   <= 4'd0;
      drain_cnt_r <= 8'd0;
    end else begin
      state_r     <= state_nxt_s;
      row_cnt_r   <= row_cnt_nxt_s;
      drain_cnt_r <= drain_cnt_nxt_s;
    end
  end

  assign state   = state_r;
  assign col_idx = drain_cnt_r[3:0];

endmodule

// File: rtl/tpmem_pingpong_ctrl.sv
// Ping-pong scheduler: steers 16-row blocks alternately into two transpose
// banks and merges their column outputs into one tagged, registered stream.
module tpmem_pingpong_ctrl
  import tpmem_pkg::*;
#(
  parameter int BW        = BW_DEFAULT,
  parameter int DRAIN_CYC = 16
) (
  input  logic              i_clk,
  input  logic              i_Reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [16*BW-1:0]  i_data,
  output logic [16*BW-1:0]  o_wr_data,
  output logic              o_wr_en0,
  output logic              o_wr_en1,
  input  logic [16*BW-1:0]  i_bank0_data,
  input  logic [16*BW-1:0]  i_bank1_data,
  input  logic              i_bank0_en,
  input  logic              i_bank1_en,
  output logic [16*BW-1:0]  o_data,
  output logic              o_valid,
  output logic [3:0]        o_col_idx,
  output logic              o_blk_last,
  output logic [7:0]        o_blk_cnt,
  output logic              o_err
);

  bank_state_e st0_s, st1_s;
  logic [3:0]  col0_s, col1_s;
  logic        row_last0_s, row_last1_s, done0_s, done1_s;
  logic        wr_sel_r;
  logic        ready_s, accept_s, wr0_s, wr1_s;
  logic        drn0_s, drn1_s, fwd0_s, fwd1_s, err_s, last_s;
  logic [16*BW-1:0] data_s;
  logic [3:0]  col_s;

  assign drn0_s   = (st0_s == DRAIN);
  assign drn1_s   = (st1_s == DRAIN);
  assign ready_s  = i_Reset & (wr_sel_r ? ~drn1_s : ~drn0_s);
  assign accept_s = i_valid & ready_s;
  assign wr0_s    = accept_s & ~wr_sel_r;
  assign wr1_s    = accept_s & wr_sel_r;
  assign o_ready  = ready_s;

  // Bank 0 wins a simultaneous request; bank 1's drain count still advances.
  assign fwd0_s = i_bank0_en & drn0_s;
  assign fwd1_s = i_bank1_en & drn1_s & ~i_bank0_en;
  assign err_s  = (i_bank0_en & ~drn0_s) | (i_bank1_en & ~drn1_s) | (i_bank0_en & i_bank1_en);
  assign data_s = fwd1_s ? i_bank1_data : i_bank0_data;
  assign col_s  = fwd1_s ? col1_s : col0_s;
  assign last_s = (fwd0_s & done0_s) | (fwd1_s & done1_s);

  tpmem_bank_fsm #(.DRAIN_CYC(DRAIN_CYC)) u_bank0 (
    .clk      (i_clk),
    .rst_n    (i_Reset),
    .wr       (wr0_s),
    .en       (i_bank0_en),
    .state    (st0_s),
    .col_idx  (col0_s),
    .row_last (row_last0_s),
    .done     (done0_s)
  );

  tpmem_bank_fsm #(.DRAIN_CYC(DRAIN_CYC)) u_bank1 (
    .clk      (i_clk),
    .rst_n    (i_Reset),
    .wr       (wr1_s),
    .en       (i_bank1_en),
    .state    (st1_s),
    .col_idx  (col1_s),
    .row_last (row_last1_s),
    .done     (done1_s)
  );

  // Write steering, merged output stream, block counter and sticky error.
  always_ff @(posedge i_clk) begin
    if (!i_Reset) begin
      wr_sel_r   <= 1'b0;
      o_wr_data  <= '0;
      o_wr_en0   <= 1'b0;
      o_wr_en1   <= 1'b0;
      o_data     <= '0;
      o_valid    <= 1'b0;
      o_col_idx  <= 4'd0;
      o_blk_last <= 1'b0;
      o_blk_cnt  <= 8'd0;
      o_err      <= 1'b0;
    end else begin
      o_wr_en0   <= wr0_s;
      o_wr_en1   <= wr1_s;
      o_valid    <= fwd0_s | fwd1_s;
      o_blk_last <= last_s;
      if (accept_s) begin
        o_wr_data <= i_data;
      end
      if (accept_s && (wr_sel_r ? row_last1_s : row_last0_s)) begin
        wr_sel_r <= ~wr_sel_r;
      end
      if (fwd0_s | fwd1_s) begin
        o_data    <= data_s;
        o_col_idx <= col_s;
      end
      if (last_s) begin
        o_blk_cnt <= o_blk_cnt + 8'd1;
      end
      if (err_s) begin
        o_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tpmem_pingpong_ctrl.sv
// Self-checking bench for tpmem_pingpong_ctrl: scenario tasks plus a random
// stream, all checked against a block-level bank occupancy model.
module tb_tpmem_pingpong_ctrl;

  localparam int BW = 11;
  localparam int W  = 16 * BW;
  localparam int DC = 16;

  logic         i_clk = 1'b0;
  logic         i_Reset = 1'b0;
  logic         i_valid = 1'b0;
  logic         o_ready;
  logic [W-1:0] i_data = '0;
  logic [W-1:0] o_wr_data;
  logic         o_wr_en0, o_wr_en1;
  logic [W-1:0] i_bank0_data = '0, i_bank1_data = '0;
  logic         i_bank0_en = 1'b0, i_bank1_en = 1'b0;
  logic [W-1:0] o_data;
  logic         o_valid;
  logic [3:0]   o_col_idx;
  logic         o_blk_last;
  logic [7:0]   o_blk_cnt;
  logic         o_err;

  int total = 0;
  int bad = 0;

  // Model: rows held by each bank (16 = full, draining), drain progress.
  int   m_fill[2];
  int   m_drn[2];
  bit   m_sel;
  int   m_blk;
  int   m_acc;
  bit   last_acc;
  bit   obs_ready;
  bit   e_ready, e_wr0, e_wr1, e_valid, e_last, e_err;
  int   e_col;
  logic [W-1:0] e_wr_data, e_data;

  always #5 i_clk = ~i_clk;

  tpmem_pingpong_ctrl #(.BW(BW), .DRAIN_CYC(DC)) dut (
    .i_clk(i_clk), .i_Reset(i_Reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_data(i_data), .o_wr_data(o_wr_data), .o_wr_en0(o_wr_en0), .o_wr_en1(o_wr_en1),
    .i_bank0_data(i_bank0_data), .i_bank1_data(i_bank1_data),
    .i_bank0_en(i_bank0_en), .i_bank1_en(i_bank1_en),
    .o_data(o_data), .o_valid(o_valid), .o_col_idx(o_col_idx),
    .o_blk_last(o_blk_last), .o_blk_cnt(o_blk_cnt), .o_err(o_err)
  );

  function automatic logic [W-1:0] rnd_row();
    logic [W-1:0] r = '0;
    for (int k = 0; k < 6; k++) r = (r << 32) | W'($urandom);
    return r;
  endfunction

  // Drive one cycle, predict its outcome from the model, advance past the edge.
  task automatic tick(input bit v, input logic [W-1:0] d, input bit e0, input bit e1);
    bit rdy, acc, ok0, ok1, f0, f1;
    bit en[2];
    i_valid = v; i_data = d; i_bank0_en = e0; i_bank1_en = e1;
    i_bank0_data = rnd_row(); i_bank1_data = rnd_row();
    #3;
    obs_ready = o_ready;
    last_acc = 1'b0;
    if (i_Reset !== 1'b1) begin
      m_fill = '{0, 0}; m_drn = '{0, 0}; m_sel = 1'b0; m_blk = 0; m_acc = 0;
      e_ready = 0; e_wr0 = 0; e_wr1 = 0; e_valid = 0; e_last = 0; e_err = 0;
      e_col = 0; e_wr_data = '0; e_data = '0;
    end else begin
      rdy = (m_fill[m_sel] < 16);
      e_ready = rdy;
      acc = v && rdy;
      ok0 = (m_fill[0] == 16); ok1 = (m_fill[1] == 16);
      e_wr0 = acc && !m_sel; e_wr1 = acc && m_sel;
      if (acc) e_wr_data = d;
      if ((e0 && !ok0) || (e1 && !ok1) || (e0 && e1)) e_err = 1'b1;
      f0 = e0 && ok0;
      f1 = e1 && ok1 && !e0;
      e_valid = f0 || f1;
      e_last = 1'b0;
      if (f0) e_data = i_bank0_data;
      if (f1) e_data = i_bank1_data;
      en[0] = e0 && ok0; en[1] = e1 && ok1;
      for (int b = 0; b < 2; b++) begin
        if (en[b]) begin
          if ((b == 0 && f0) || (b == 1 && f1)) begin
            e_col = m_drn[b] % 16;
            e_last = (m_drn[b] == DC - 1);
            if (e_last) m_blk = (m_blk + 1) % 256;
          end
          m_drn[b]++;
          if (m_drn[b] == DC) begin m_drn[b] = 0; m_fill[b] = 0; end
        end
      end
      if (acc) begin
        m_acc++; last_acc = 1'b1;
        m_fill[m_sel]++;
        if (m_fill[m_sel] == 16) m_sel = !m_sel;
      end
    end
    @(posedge i_clk); #1;
  endtask

  task automatic do_reset();
    i_Reset = 1'b0;
    tick(1'b0, '0, 1'b0, 1'b0);
    i_Reset = 1'b1;
  endtask

  task automatic test_reset();
    i_Reset = 1'b0;
    tick(1'b1, rnd_row(), 1'b1, 1'b1);
    tick(1'b1, rnd_row(), 1'b0, 1'b1);
    total++; if (obs_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", obs_ready); end
    total++; if ({o_wr_en0, o_wr_en1, o_valid, o_blk_last, o_err} !== 5'd0) begin bad++;
      $display("FAIL reset_flags got=%b exp=00000", {o_wr_en0, o_wr_en1, o_valid, o_blk_last, o_err}); end
    total++; if (o_blk_cnt !== 8'd0 || o_col_idx !== 4'd0) begin bad++;
      $display("FAIL reset_counts got=%0d/%0d exp=0/0", o_blk_cnt, o_col_idx); end
    total++; if (o_wr_data !== '0 || o_data !== '0) begin bad++;
      $display("FAIL reset_data got=%h/%h exp=0", o_wr_data, o_data); end
    i_Reset = 1'b1;
  endtask

  task automatic test_fill_bank0();
    logic [W-1:0] d;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      d = rnd_row();
      tick(1'b1, d, 1'b0, 1'b0);
      total++; if (obs_ready !== 1'b1) begin bad++; $display("FAIL fill_ready row=%0d got=%b exp=1", i, obs_ready); end
      total++; if (o_wr_en0 !== 1'b1 || o_wr_en1 !== 1'b0) begin bad++;
        $display("FAIL fill_wr_en row=%0d got=%b%b exp=10", i, o_wr_en0, o_wr_en1); end
      total++; if (o_wr_data !== d) begin bad++; $display("FAIL fill_wr_data row=%0d got=%h exp=%h", i, o_wr_data, d); end
    end
    tick(1'b0, '0, 1'b0, 1'b0);
    total++; if (obs_ready !== 1'b1 || o_wr_en0 !== 1'b0) begin bad++;
      $display("FAIL fill_after got=ready%b/en%b exp=1/0", obs_ready, o_wr_en0); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 32; i++) begin
      tick(1'b1, rnd_row(), 1'b0, 1'b0);
      total++; if (o_wr_en0 !== (i < 16) || o_wr_en1 !== (i >= 16) || obs_ready !== 1'b1) begin bad++;
        $display("FAIL b2b_wr row=%0d got=en%b%b/rdy%b exp=en%b%b/rdy1", i, o_wr_en0, o_wr_en1, obs_ready, i < 16, i >= 16); end
    end
    for (int k = 0; k < 16; k++) begin
      tick(1'b0, '0, 1'b1, 1'b0);
      total++; if (o_valid !== 1'b1 || o_data !== i_bank0_data) begin bad++;
        $display("FAIL b2b_data col=%0d got=v%b %h exp=v1 %h", k, o_valid, o_data, i_bank0_data); end
      total++; if (o_col_idx !== 4'(k) || o_blk_last !== (k == 15)) begin bad++;
        $display("FAIL b2b_idx col=%0d got=%0d/last%b exp=%0d/last%b", k, o_col_idx, o_blk_last, k, k == 15); end
    end
    total++; if (o_blk_cnt !== 8'd1 || o_err !== 1'b0) begin bad++;
      $display("FAIL b2b_blk_cnt got=%0d/err%b exp=1/err0", o_blk_cnt, o_err); end
  endtask

  task automatic test_stall();
    int t32 = -1;
    int ens = 0;
    int cyc = 0;
    int wr_seen = 0;
    bit e0;
    logic [W-1:0] d;
    logic [W-1:0] q[$];
    do_reset();
    while (m_acc < 48 && cyc < 300) begin
      e0 = (t32 >= 0) && (cyc >= t32 + 4) && (ens < 16);
      if (e0) ens++;
      d = rnd_row();
      tick(1'b1, d, e0, 1'b0);
      if (last_acc) q.push_back(d);
      if (m_acc == 32 && t32 < 0) t32 = cyc;
      total++; if (obs_ready !== e_ready) begin bad++; $display("FAIL stall_ready cyc=%0d got=%b exp=%b", cyc, obs_ready, e_ready); end
      total++; if (o_wr_en0 !== e_wr0 || o_wr_en1 !== e_wr1) begin bad++;
        $display("FAIL stall_wr_en cyc=%0d got=%b%b exp=%b%b", cyc, o_wr_en0, o_wr_en1, e_wr0, e_wr1); end
      if (o_wr_en0 === 1'b1 || o_wr_en1 === 1'b1) begin
        wr_seen++;
        total++;
        if (q.size() == 0) begin bad++; $display("FAIL stall_extra_write cyc=%0d got=write exp=none", cyc); end
        else if (o_wr_data !== q[0]) begin bad++; $display("FAIL stall_order cyc=%0d got=%h exp=%h", cyc, o_wr_data, q[0]); void'(q.pop_front()); end
        else void'(q.pop_front());
      end
      cyc++;
    end
    total++; if (wr_seen !== 48 || m_acc !== 48) begin bad++;
      $display("FAIL stall_rows got=%0d writes/%0d accepts exp=48", wr_seen, m_acc); end
  endtask

  task automatic test_err_empty();
    do_reset();
    tick(1'b0, '0, 1'b0, 1'b1);
    total++; if (o_valid !== 1'b0 || o_err !== 1'b1) begin bad++;
      $display("FAIL err_empty got=v%b err%b exp=v0 err1", o_valid, o_err); end
    for (int i = 0; i < 3; i++) tick(1'b0, '0, 1'b0, 1'b0);
    total++; if (o_err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", o_err); end
    do_reset();
    total++; if (o_err !== 1'b0) begin bad++; $display("FAIL err_clear got=%b exp=0", o_err); end
  endtask

  task automatic test_dual_en();
    do_reset();
    for (int i = 0; i < 32; i++) tick(1'b1, rnd_row(), 1'b0, 1'b0);
    tick(1'b0, '0, 1'b1, 1'b1);
    total++; if (o_valid !== 1'b1 || o_data !== i_bank0_data || o_err !== 1'b1) begin bad++;
      $display("FAIL dual_en got=v%b err%b %h exp=v1 err1 %h", o_valid, o_err, o_data, i_bank0_data); end
    for (int i = 0; i < 30; i++) begin
      tick(1'b0, '0, i < 15, i >= 15);
      total++; if (o_col_idx !== 4'(e_col) || o_blk_last !== e_last || o_data !== e_data) begin bad++;
        $display("FAIL dual_drain i=%0d got=%0d/last%b exp=%0d/last%b", i, o_col_idx, o_blk_last, e_col, e_last); end
    end
    total++; if (o_blk_cnt !== 8'd2) begin bad++; $display("FAIL dual_blk_cnt got=%0d exp=2", o_blk_cnt); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 8; i++) tick(1'b1, rnd_row(), 1'b0, 1'b0);
    i_Reset = 1'b0;
    tick(1'b1, rnd_row(), 1'b0, 1'b0);
    i_Reset = 1'b1;
    total++; if ({o_wr_en0, o_wr_en1, o_valid, o_blk_last, o_err, o_blk_cnt, o_col_idx} !== 17'd0 || o_wr_data !== '0) begin bad++;
      $display("FAIL midrst_outputs got=%b%b%b%b%b/%0d/%0d exp=all zero", o_wr_en0, o_wr_en1, o_valid, o_blk_last, o_err, o_blk_cnt, o_col_idx); end
    for (int i = 0; i < 16; i++) begin
      tick(1'b1, rnd_row(), 1'b0, 1'b0);
      total++; if (o_wr_en0 !== 1'b1 || o_wr_en1 !== 1'b0) begin bad++;
        $display("FAIL midrst_bank row=%0d got=%b%b exp=10", i, o_wr_en0, o_wr_en1); end
    end
    tick(1'b1, rnd_row(), 1'b0, 1'b0);
    total++; if (o_wr_en1 !== 1'b1) begin bad++; $display("FAIL midrst_next_bank got=%b exp=1", o_wr_en1); end
  endtask

  task automatic test_random();
    bit v, e0, e1;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      v  = ($urandom_range(0, 3) != 0);
      e0 = (m_fill[0] == 16) && ($urandom_range(0, 2) != 0);
      e1 = (m_fill[1] == 16) && !e0 && ($urandom_range(0, 1) != 0);
      tick(v, rnd_row(), e0, e1);
      total++; if (obs_ready !== e_ready || o_wr_en0 !== e_wr0 || o_wr_en1 !== e_wr1) begin bad++;
        $display("FAIL rnd_write c=%0d got=rdy%b en%b%b exp=rdy%b en%b%b", c, obs_ready, o_wr_en0, o_wr_en1, e_ready, e_wr0, e_wr1); end
      if (e_wr0 || e_wr1) begin
        total++; if (o_wr_data !== e_wr_data) begin bad++; $display("FAIL rnd_wr_data c=%0d got=%h exp=%h", c, o_wr_data, e_wr_data); end
      end
      total++; if (o_valid !== e_valid || o_blk_last !== e_last || o_blk_cnt !== 8'(m_blk) || o_err !== e_err) begin bad++;
        $display("FAIL rnd_out c=%0d got=v%b l%b n%0d e%b exp=v%b l%b n%0d e%b", c, o_valid, o_blk_last, o_blk_cnt, o_err, e_valid, e_last, m_blk, e_err); end
      if (e_valid) begin
        total++; if (o_data !== e_data || o_col_idx !== 4'(e_col)) begin bad++;
          $display("FAIL rnd_data c=%0d got=%0d %h exp=%0d %h", c, o_col_idx, o_data, e_col, e_data); end
      end
    end
  endtask

  initial begin
    @(posedge i_clk); #1;
    test_reset();
    test_fill_bank0();
    test_back_to_back();
    test_stall();
    test_err_empty();
    test_dual_en();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
